fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC and issues requests to instruction memory over a request/grant plus response handshake.
- Buffers returned instructions in a small FIFO and presents instr, pc and pc+4 to the decode stage under a valid/ready handshake.
- Accepts a redirect from the execute stage (taken branch, jal, jalr), flushes queued instructions and discards stale in-flight responses.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: reset PC, canonical NOP, control-flow opcodes
// and the fetch buffer entry layout.
package rv_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. DEPTH must be a power of two so the pointers wrap
// naturally; count is one bit wider than the pointers to represent "full".
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, PC tag queue and decode buffer.
// Optional misaligned-redirect trap selected with FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] occupancy, outstanding;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_pc, tag_pc;
  logic          fault_active;
  logic          req_fire, rvalid_ok, fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty, tag_full, tag_empty;
  fetch_entry_t  head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = is_misaligned(redirect_target) ? FETCH_FAULT : FETCH_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH_RUN;
    else       state_q <= state_d;
  end

  assign fault_active = (state_q == FETCH_FAULT);
  assign redirect_pc  = redirect_target;
`else
  assign fault_active = 1'b0;
  assign redirect_pc  = redirect_target & 32'hFFFF_FFFC;
`endif

  assign fetch_fault = fault_active;

  // Occupancy plus in-flight words must never exceed the buffer, so every response has a slot.
  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req    = !reset && !fault_active && !redirect_valid &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = pc_q;

  assign req_fire   = imem_req && imem_gnt;
  assign rvalid_ok  = imem_rvalid && !tag_empty;
  assign fifo_push  = rvalid_ok && (discard_q == '0) && !redirect_valid && !fault_active;
  assign fifo_pop   = instr_valid && instr_ready && !redirect_valid;
  assign fifo_flush = redirect_valid || fault_active;
  assign push_entry = '{pc: tag_pc, instr: imem_rdata};

  // Stale responses are counted off by discard; a same-cycle response is already gone.
  always_comb begin
    pc_d      = pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      discard_d = outstanding + CW'(req_fire) - CW'(rvalid_ok);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rvalid_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_queue (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rvalid_ok),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (outstanding)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_instr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? NOP_INSTR : head.instr;
  assign instr_pc    = fifo_empty ? RESET_PC  : head.pc;
  assign instr_pc4   = instr_pc + 32'd4;

  rvalid_has_outstanding: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> !tag_empty);
  tag_queue_no_overflow: assert property (@(posedge clk) disable iff (reset)
    req_fire |-> !tag_full);
  instr_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (fifo_push && !fifo_pop) |-> !fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with controllable grant and
// response release, expected PC stream tracked in the bench.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        fetch_fault;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc4       (instr_pc4),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          accepts      = 0;
  logic [31:0] mem_q[$];
  logic [31:0] exp_pc, exp_req_addr;
  logic        gnt_en, resp_en;
  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] model_redirect(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, update memory model at the edge.
  task automatic applyStimulus(input logic red_v, input logic [31:0] red_t, input logic ready);
    redirect_valid  = red_v;
    redirect_target = red_t;
    instr_ready     = ready;
    imem_gnt        = gnt_en;
    imem_rvalid     = resp_en && (mem_q.size() > 0);
    imem_rdata      = imem_rvalid ? mem_word(mem_q[0]) : 32'hDEAD_BEEF;
    #2;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_instr = instr;
    s_pc    = instr_pc;
    s_pc4   = instr_pc4;
    s_fault = fetch_fault;
    if (red_v) checkOutput("req_during_redirect", 32'(s_req), 32'd0);
    if (s_valid && ready && !red_v) begin
      checkOutput("instr_pc", s_pc, exp_pc);
      checkOutput("instr", s_instr, mem_word(exp_pc));
      checkOutput("instr_pc4", s_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (s_req && gnt_en) begin
      checkOutput("imem_addr", s_addr, exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
      accepts++;
    end
    if (red_v) begin
      exp_pc       = model_redirect(red_t);
      exp_req_addr = model_redirect(red_t);
    end
    @(posedge clk);
    if (imem_rvalid) void'(mem_q.pop_front());
    if (s_req && gnt_en) mem_q.push_back(s_addr);
    #1;
  endtask

  task automatic waitValid(input string tag, input logic [31:0] exp_head);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      seen = s_valid;
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_pc"}, s_pc, exp_head);
  endtask

  task automatic drain(input string tag);
    gnt_en  = 1'b0;
    resp_en = 1'b1;
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput({tag, "_empty"}, 32'(s_valid), 32'd0);
    checkOutput({tag, "_all_consumed"}, exp_pc, exp_req_addr);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
    gnt_en = 1'b0; resp_en = 1'b0; exp_pc = '0; exp_req_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_pc", instr_pc, 32'h0);
    checkOutput("rst_pc4", instr_pc4, 32'h4);
    checkOutput("rst_fault", 32'(fetch_fault), 32'd0);
    reset = 1'b0;

    // Streaming: gnt always, response one cycle later, decode ready.
    $display("[TB] streaming fetch");
    gnt_en = 1'b1; resp_en = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c0_req", 32'(s_req), 32'd1);
    checkOutput("c0_valid", 32'(s_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c1_valid", 32'(s_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c2_valid", 32'(s_valid), 32'd1);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1);
    drain("stream");

    // Backpressure: only FIFO_DEPTH requests may be issued while decode stalls.
    $display("[TB] decode backpressure");
    gnt_en = 1'b1; resp_en = 1'b1; accepts = 0;
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("stall_accepts", 32'(accepts), 32'(DEPTH));
    checkOutput("stall_req", 32'(s_req), 32'd0);
    checkOutput("stall_valid", 32'(s_valid), 32'd1);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
    drain("stall");

    // Two requests in flight, then redirect: both responses must be dropped.
    $display("[TB] redirect with two outstanding");
    applyStimulus(1'b1, 32'h0000_0010, 1'b1);
    gnt_en = 1'b1; resp_en = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("credit_block_req", 32'(s_req), 32'd0);
    applyStimulus(1'b1, 32'h0000_0100, 1'b1);
    resp_en = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("valid_after_redirect", 32'(s_valid), 32'd0);
    waitValid("redir_0x100", 32'h0000_0100);
    drain("redir_0x100");

    // Redirect coinciding with a response and a decode pop.
    $display("[TB] redirect with rvalid and pop");
    applyStimulus(1'b1, 32'h0000_0040, 1'b0);
    gnt_en = 1'b1; resp_en = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0300, 1'b1);
    checkOutput("valid_before_redirect", 32'(s_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("fifo_flushed", 32'(s_valid), 32'd0);
    waitValid("redir_0x300", 32'h0000_0300);
    drain("redir_0x300");

    // Redirect with a response in the same cycle and one more still in flight.
    $display("[TB] redirect leaving one to discard");
    applyStimulus(1'b1, 32'h0000_0080, 1'b1);
    gnt_en = 1'b1; resp_en = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    resp_en = 1'b1;
    applyStimulus(1'b1, 32'h0000_0400, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("valid_after_redirect2", 32'(s_valid), 32'd0);
    waitValid("redir_0x400", 32'h0000_0400);
    drain("redir_0x400");

    // Back-to-back redirects: the last target wins.
    $display("[TB] back-to-back redirects");
    applyStimulus(1'b1, 32'h0000_00C0, 1'b1);
    gnt_en = 1'b1; resp_en = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0500, 1'b1);
    resp_en = 1'b1;
    applyStimulus(1'b1, 32'h0000_0600, 1'b1);
    waitValid("redir_0x600", 32'h0000_0600);
    drain("redir_0x600");

    // PC wrap-around at the top of the address space.
    $display("[TB] pc wrap");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    gnt_en = 1'b1; resp_en = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap_first_addr", s_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap_req", 32'(s_req), 32'd1);
    checkOutput("wrap_addr", s_addr, 32'h0000_0000);
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
    drain("wrap");

    // Misaligned redirect target.
    $display("[TB] misaligned redirect");
`ifdef FETCH_MISALIGN_TRAP_EN
    gnt_en = 1'b1; resp_en = 1'b1;
    applyStimulus(1'b1, 32'h0000_0102, 1'b0);
    accepts = 0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("trap_fault", 32'(s_fault), 32'd1);
    checkOutput("trap_req", 32'(s_req), 32'd0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("trap_accepts", 32'(accepts), 32'd0);
    checkOutput("trap_valid", 32'(s_valid), 32'd0);
    applyStimulus(1'b1, 32'h0000_0200, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("trap_cleared", 32'(s_fault), 32'd0);
    checkOutput("trap_resume_req", 32'(s_req), 32'd1);
    checkOutput("trap_resume_addr", s_addr, 32'h0000_0200);
    waitValid("trap_0x200", 32'h0000_0200);
    drain("trap");
`else
    applyStimulus(1'b1, 32'h0000_0102, 1'b0);
    gnt_en = 1'b1; resp_en = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("misalign_fault", 32'(s_fault), 32'd0);
    checkOutput("misalign_req", 32'(s_req), 32'd1);
    checkOutput("misalign_addr", s_addr, 32'h0000_0100);
    waitValid("misalign_0x100", 32'h0000_0100);
    drain("misalign");
`endif

    // Asynchronous reset in the middle of a transaction.
    $display("[TB] reset mid-transaction");
    gnt_en = 1'b1; resp_en = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pre_reset_valid", 32'(s_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(instr_valid), 32'd0);
    checkOutput("arst_req", 32'(imem_req), 32'd0);
    checkOutput("arst_instr", instr, 32'h0000_0013);
    checkOutput("arst_pc", instr_pc, 32'h0);
    checkOutput("arst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    mem_q.delete();
    exp_pc = '0; exp_req_addr = '0;
    reset = 1'b0;
    waitValid("post_reset", 32'h0000_0000);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
